// File: rtl/div_pkg.sv
// Shared types for the sequential divider: operation encodings, FSM states
// and small decode helpers used by the divider and the issue/decode logic.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
// The master drives requests and flush; the slave (divider) returns status and result.
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             flush_i;
  logic             start_i;
  div_op_e          op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output flush_i, start_i, op_i, dividend_i, divisor_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  flush_i, start_i, op_i, dividend_i, divisor_i,
    output ready_o, busy_o, valid_o, result_o
  );

endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with a fixed WIDTH-iteration
// loop, single-cycle shortcut for divide-by-zero and signed overflow, and flush.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  div_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  div_op_e            op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic               in_div_zero;
  logic               in_overflow;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH:0]     abs_b;
  logic [2*WIDTH:0]   step_res;

  // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
  // The compare is done at WIDTH+1 bits so a full-range unsigned divisor never truncates.
  function automatic logic [2*WIDTH:0] div_step(logic [WIDTH:0]   rem,
                                                logic [WIDTH-1:0] quo,
                                                logic [WIDTH:0]   dvsr);
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    rem_sh = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
    quo_sh = quo << 1;
    if (rem_sh >= dvsr) begin
      rem_sh    = rem_sh - dvsr;
      quo_sh[0] = 1'b1;
    end
    return {rem_sh, quo_sh};
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(div_op_e          op,
                                                logic             neg_a,
                                                logic             neg_b,
                                                logic [WIDTH:0]   rem,
                                                logic [WIDTH-1:0] quo);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    q = ((op == OP_DIV) && (neg_a ^ neg_b)) ? (~quo + 1'b1) : quo;
    r = ((op == OP_REM) && neg_a) ? WIDTH'(~rem + 1'b1) : WIDTH'(rem);
    return is_rem_op(op) ? r : q;
  endfunction

  assign in_signed   = is_signed_op(bus.op_i);
  assign in_neg_a    = in_signed & bus.dividend_i[WIDTH-1];
  assign in_neg_b    = in_signed & bus.divisor_i[WIDTH-1];
  assign in_div_zero = (bus.divisor_i == '0);
  assign in_overflow = in_signed && (bus.dividend_i == MIN_VAL) && (bus.divisor_i == '1);
  assign abs_a       = in_neg_a ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
  assign abs_b       = {1'b0, (in_neg_b ? (~bus.divisor_i + 1'b1) : bus.divisor_i)};
  assign step_res    = div_step(rem_q, quo_q, dvsr_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;

    // Flush wins over everything, including an accept in IDLE and the DONE pulse.
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            op_d    = bus.op_i;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            rem_d   = '0;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
            cnt_d   = '0;
            if (in_div_zero) begin
              result_d = is_rem_op(bus.op_i) ? bus.dividend_i : '1;
              state_d  = ST_DONE;
            end else if (in_overflow) begin
              result_d = is_rem_op(bus.op_i) ? '0 : MIN_VAL;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_d = step_res[2*WIDTH:WIDTH];
          quo_d = step_res[WIDTH-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = sign_fix(op_q, neg_a_q, neg_b_q, rem_q, quo_q);
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_DIV;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.valid_o  = (state_q == ST_DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 32-bit instance for architectural cases, flush
// and reset, plus an 8-bit instance checked against a behavioural reference.
module tb_div_seq;
  import div_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  div_if #(.WIDTH(32)) b32 ();
  div_if #(.WIDTH(8))  b8 ();

  div_seq #(.WIDTH(32)) u_div32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  div_seq #(.WIDTH(8))  u_div8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Issue one request on the 32-bit instance; report the edge index (0 = accept
  // edge) after which valid_o was seen, and whether ready_o stayed low until then.
  task automatic run32(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int edge_n, output bit ready_low);
    @(negedge clk);
    b32.op_i       = op;
    b32.dividend_i = a;
    b32.divisor_i  = b;
    b32.start_i    = 1'b1;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    edge_n    = -1;
    ready_low = 1'b1;
    res       = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b32.ready_o || !b32.busy_o) ready_low = 1'b0;
      if (b32.valid_o) begin
        edge_n = k;
        res    = b32.result_o;
        break;
      end
    end
    $display("txn w32 op=%s a=%h b=%h result=%h valid_edge=%0d", op.name(), a, b, res, edge_n);
  endtask

  task automatic run8(input div_op_e op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] res, output int edge_n);
    @(negedge clk);
    b8.op_i       = op;
    b8.dividend_i = a;
    b8.divisor_i  = b;
    b8.start_i    = 1'b1;
    @(posedge clk);
    #1;
    b8.start_i = 1'b0;
    edge_n = -1;
    res    = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b8.valid_o) begin
        edge_n = k;
        res    = b8.result_o;
        break;
      end
    end
  endtask

  function automatic logic [7:0] ref8(div_op_e op, logic [7:0] a, logic [7:0] b);
    int sa;
    int sb;
    if (b == 8'h00) return (op == OP_DIV || op == OP_DIVU) ? 8'hFF : a;
    if ((op == OP_DIV || op == OP_REM) && a == 8'h80 && b == 8'hFF)
      return (op == OP_DIV) ? 8'h80 : 8'h00;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      OP_DIVU: return a / b;
      OP_REMU: return a % b;
      OP_DIV:  return 8'(sa / sb);
      default: return 8'(sa % sb);
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (b32.ready_o !== 1'b1 || b32.busy_o !== 1'b0 || b32.valid_o !== 1'b0 || b32.result_o !== 32'h0)
      $display("FAIL reset32 got ready=%b busy=%b valid=%b result=%h required 1 0 0 00000000",
               b32.ready_o, b32.busy_o, b32.valid_o, b32.result_o);
    else passed++;
    checks++;
    if (b8.ready_o !== 1'b1 || b8.busy_o !== 1'b0 || b8.valid_o !== 1'b0 || b8.result_o !== 8'h0)
      $display("FAIL reset8 got ready=%b busy=%b valid=%b result=%h required 1 0 0 00",
               b8.ready_o, b8.busy_o, b8.valid_o, b8.result_o);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int          e;
    bit          rl;
    div_op_e     ops[2] = '{OP_DIVU, OP_REMU};
    logic [31:0] exp[2] = '{32'd14, 32'd2};
    for (int i = 0; i < 2; i++) begin
      run32(ops[i], 32'd100, 32'd7, res, e, rl);
      checks++;
      if (res !== exp[i] || e != 33 || !rl)
        $display("FAIL unsigned_%0d got result=%h edge=%0d ready_low=%b required %h 33 1",
                 i, res, e, rl, exp[i]);
      else passed++;
      @(negedge clk);
      checks++;
      if (b32.valid_o !== 1'b0 || b32.ready_o !== 1'b1)
        $display("FAIL pulse_%0d got valid=%b ready=%b required 0 1", i, b32.valid_o, b32.ready_o);
      else passed++;
    end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int          e;
    bit          rl;
    div_op_e     ops[5] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU};
    logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000};
    logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] exp[5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run32(ops[i], as[i], bs[i], res, e, rl);
      checks++;
      if (res !== exp[i] || e != 33 || !rl)
        $display("FAIL signed_%0d got result=%h edge=%0d ready_low=%b required %h 33 1",
                 i, res, e, rl, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_special();
    logic [31:0] res;
    int          e;
    bit          rl;
    div_op_e     ops[5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_REMU};
    logic [31:0] as[5]  = '{32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'd7};
    logic [31:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] exp[5] = '{32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'd0, 32'd7};
    for (int i = 0; i < 5; i++) begin
      run32(ops[i], as[i], bs[i], res, e, rl);
      checks++;
      if (res !== exp[i] || e != 0 || !rl)
        $display("FAIL special_%0d got result=%h edge=%0d ready_low=%b required %h 0 1",
                 i, res, e, rl, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int          e;
    int          pulses;
    logic [31:0] res;
    @(negedge clk);
    b32.op_i       = OP_DIVU;
    b32.dividend_i = 32'd100;
    b32.divisor_i  = 32'd7;
    b32.start_i    = 1'b1;
    @(posedge clk);
    e = -1;
    res = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (b32.valid_o) begin
        e = k;
        res = b32.result_o;
        break;
      end
      b32.op_i       = k[0] ? OP_REM : OP_DIVU;
      b32.dividend_i = 32'd1000 + 32'(k);
      b32.divisor_i  = 32'd3;
    end
    $display("txn w32 busy-start first result=%h valid_edge=%0d", res, e);
    checks++;
    if (res !== 32'd14 || e != 33)
      $display("FAIL busy_ignore got result=%h edge=%0d required 0000000e 33", res, e);
    else passed++;
    b32.op_i       = OP_DIVU;
    b32.dividend_i = 32'd50;
    b32.divisor_i  = 32'd5;
    @(negedge clk);
    checks++;
    if (b32.ready_o !== 1'b1 || b32.valid_o !== 1'b0)
      $display("FAIL idle_after_done got ready=%b valid=%b required 1 0", b32.ready_o, b32.valid_o);
    else passed++;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    e = -1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (b32.valid_o) begin
        if (pulses == 0) begin
          e = k;
          res = b32.result_o;
        end
        pulses++;
      end
    end
    $display("txn w32 op=OP_DIVU a=00000032 b=00000005 result=%h valid_edge=%0d", res, e);
    checks++;
    if (res !== 32'd10 || e != 33 || pulses != 1)
      $display("FAIL second_accept got result=%h edge=%0d pulses=%0d required 0000000a 33 1",
               res, e, pulses);
    else passed++;
  endtask

  task automatic test_flush();
    int          pulses;
    logic [31:0] res;
    int          e;
    bit          rl;
    @(negedge clk);
    b32.op_i       = OP_DIVU;
    b32.dividend_i = 32'd9;
    b32.divisor_i  = 32'd3;
    b32.start_i    = 1'b1;
    b32.flush_i    = 1'b1;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    b32.flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.ready_o !== 1'b1 || b32.busy_o !== 1'b0)
      $display("FAIL flush_start_idle got ready=%b busy=%b required 1 0", b32.ready_o, b32.busy_o);
    else passed++;
    @(negedge clk);
    b32.dividend_i = 32'd1000;
    b32.start_i    = 1'b1;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    b32.flush_i = 1'b1;
    @(posedge clk);
    #1;
    b32.flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.ready_o !== 1'b1 || b32.busy_o !== 1'b0 || b32.valid_o !== 1'b0 || b32.result_o !== 32'd10)
      $display("FAIL flush_calc got ready=%b busy=%b valid=%b result=%h required 1 0 0 0000000a",
               b32.ready_o, b32.busy_o, b32.valid_o, b32.result_o);
    else passed++;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.valid_o) pulses++;
    end
    checks++;
    if (pulses != 0 || b32.result_o !== 32'd10)
      $display("FAIL flush_quiet got pulses=%0d result=%h required 0 0000000a", pulses, b32.result_o);
    else passed++;
    run32(OP_DIVU, 32'd1000, 32'd3, res, e, rl);
    checks++;
    if (res !== 32'd333 || e != 33 || !rl)
      $display("FAIL after_flush got result=%h edge=%0d ready_low=%b required 0000014d 33 1", res, e, rl);
    else passed++;
  endtask

  task automatic test_async_reset();
    int pulses;
    @(negedge clk);
    b32.op_i       = OP_DIV;
    b32.dividend_i = 32'd1000;
    b32.divisor_i  = 32'd7;
    b32.start_i    = 1'b1;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b32.ready_o !== 1'b1 || b32.busy_o !== 1'b0 || b32.valid_o !== 1'b0 || b32.result_o !== 32'h0)
      $display("FAIL async_reset got ready=%b busy=%b valid=%b result=%h required 1 0 0 00000000",
               b32.ready_o, b32.busy_o, b32.valid_o, b32.result_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.valid_o) pulses++;
    end
    checks++;
    if (pulses != 0)
      $display("FAIL reset_drop got pulses=%0d required 0", pulses);
    else passed++;
  endtask

  task automatic test_width8();
    logic [7:0] vals[9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] exp;
    div_op_e    op;
    int         e;
    int         exp_e;
    int         total;
    total = 4 * 81 + 1200;
    for (int n = 0; n < total; n++) begin
      if (n < 4 * 81) begin
        op = div_op_e'(n % 4);
        a  = vals[(n / 4) % 9];
        b  = vals[(n / 36) % 9];
      end else begin
        op = div_op_e'($urandom_range(0, 3));
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
      end
      exp   = ref8(op, a, b);
      exp_e = (b == 8'h00 || (is_signed_op(op) && a == 8'h80 && b == 8'hFF)) ? 0 : 9;
      run8(op, a, b, res, e);
      $display("txn w8 op=%s a=%h b=%h result=%h valid_edge=%0d", op.name(), a, b, res, e);
      checks++;
      if (res !== exp || e != exp_e)
        $display("FAIL w8 op=%s a=%h b=%h got result=%h edge=%0d required %h %0d",
                 op.name(), a, b, res, e, exp, exp_e);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0;
    b32.flush_i = 1'b0; b32.start_i = 1'b0; b32.op_i = OP_DIV;
    b32.dividend_i = '0; b32.divisor_i = '0;
    b8.flush_i = 1'b0; b8.start_i = 1'b0; b8.op_i = OP_DIV;
    b8.dividend_i = '0; b8.divisor_i = '0;
    #1;
    rst = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_width8();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
